// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel and FIFO-entry types, arbiter state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int PIX_W    = 12;
   localparam int ROW_W    = 9;
   localparam int COL_W    = 10;
   localparam int ADDR_W   = ROW_W + COL_W;

   // bbbb_gggg_rrrr
   typedef logic [PIX_W-1:0] pixel_t;

   // 31-bit write-buffer entry {row, col, data}
   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      pixel_t           data;
   } pix_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } arb_state_t;

   function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      return {row, col};
   endfunction
endpackage

// File: rtl/pix_fifo.sv
// Synchronous write buffer for pending pixel writes, head visible combinationally.
// Latency: an entry pushed at edge N is at the head from edge N onward if the FIFO was empty.
// Backpressure: o_full blocks pushes; pops on empty are ignored; simultaneous push+pop keeps level.
// Ports: vga_clk/clrn, i_push/i_push_dat, i_pop, o_head_dat, o_full, o_empty, o_level.
module pix_fifo
   import vga_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     vga_clk,
   input  logic                     clrn,
   input  logic                     i_push,
   input  pix_entry_t               i_push_dat,
   input  logic                     i_pop,
   output pix_entry_t               o_head_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   pix_entry_t         r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [LVL_W-1:0]   r_level;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_full     = (r_level == LVL_W'(DEPTH));
   assign o_empty    = (r_level == '0);
   assign o_level    = r_level;
   assign o_head_dat = r_mem[r_rd_ptr];
   assign w_do_push  = i_push & ~o_full;
   assign w_do_pop   = i_pop & ~o_empty;

   // Storage needs no reset: only slots behind a valid level are ever read out.
   always_ff @(posedge vga_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end
endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port pixel RAM: scan-out reads always win, buffered writes and screen clear use idle cycles.
// Latency: write accepted at edge N into an idle, empty buffer commits at edge N+2; RAM outputs are combinational.
// Backpressure: wr_ready drops when the buffer is full; rdn=0 stalls draining and clearing for that cycle.
// Ports: VGA side (row_addr, col_addr, rdn, d_in), draw side (wr_*, clr_*), RAM side (ram_*), status (fifo_level, wr_dropped).
module vram_arbiter
   import vga_pkg::*;
#(
   parameter int             FIFO_DEPTH    = 8,
   parameter logic [11:0]    CLR_COLOR_RST = 12'h000,
   // Screen geometry; defaults to the full VGA frame.
   parameter int             V_PIX         = V_ACTIVE,
   parameter int             H_PIX         = H_ACTIVE
) (
   input  logic                          vga_clk,
   input  logic                          clrn,
   input  logic [8:0]                    row_addr,
   input  logic [9:0]                    col_addr,
   input  logic                          rdn,
   output logic [11:0]                   d_in,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [8:0]                    wr_row,
   input  logic [9:0]                    wr_col,
   input  logic [11:0]                   wr_data,
   input  logic                          clr_req,
   input  logic [11:0]                   clr_color,
   output logic                          clr_busy,
   output logic [18:0]                   ram_addr,
   output logic                          ram_we,
   output logic [11:0]                   ram_wdata,
   input  logic [11:0]                   ram_rdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          wr_dropped
);
   localparam int               LVL_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_PIX - 1);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_PIX - 1);

   arb_state_t         r_state;
   arb_state_t         w_next_state;
   logic [ROW_W-1:0]   r_clr_row;
   logic [COL_W-1:0]   r_clr_col;
   pixel_t             r_clr_color;
   logic               r_wr_dropped;

   logic               w_full;
   logic               w_empty;
   logic [LVL_W-1:0]   w_level;
   pix_entry_t         w_head;
   pix_entry_t         w_push_dat;
   logic               w_accept;
   logic               w_in_range;
   logic               w_push;
   logic               w_pop;
   logic               w_clr_last;

   assign d_in       = ram_rdata;
   assign wr_ready   = ~w_full;
   assign fifo_level = w_level;
   assign wr_dropped = r_wr_dropped;
   assign clr_busy   = (r_state == ST_CLEAR);

   // Out-of-range writes still complete the handshake but never reach the buffer.
   assign w_accept   = wr_valid & ~w_full;
   assign w_in_range = (wr_row <= ROW_MAX) && (wr_col <= COL_MAX);
   assign w_push     = w_accept & w_in_range;
   assign w_push_dat = '{row: wr_row, col: wr_col, data: wr_data};
   assign w_clr_last = (r_clr_row == ROW_MAX) && (r_clr_col == COL_MAX);

   pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .vga_clk    (vga_clk),
      .clrn       (clrn),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_level    (w_level)
   );

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (clr_req)       w_next_state = ST_CLEAR;
            else if (!w_empty) w_next_state = ST_DRAIN;
         end
         // Leave only when this pop really empties the buffer (no refill in the same cycle).
         ST_DRAIN: if (rdn && (w_level == LVL_W'(1)) && !w_push) w_next_state = ST_IDLE;
         ST_CLEAR: if (rdn && w_clr_last) w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // RAM port mux; gated by clrn so nothing is written while reset is held.
   always_comb begin
      ram_addr  = pack_addr(row_addr, col_addr);
      ram_we    = 1'b0;
      ram_wdata = '0;
      w_pop     = 1'b0;
      if (clrn && rdn) begin
         case (r_state)
            ST_DRAIN: begin
               ram_we    = 1'b1;
               ram_addr  = pack_addr(w_head.row, w_head.col);
               ram_wdata = w_head.data;
               w_pop     = 1'b1;
            end
            ST_CLEAR: begin
               ram_we    = 1'b1;
               ram_addr  = pack_addr(r_clr_row, r_clr_col);
               ram_wdata = r_clr_color;
            end
            default: ;
         endcase
      end
      if (!clrn) ram_addr = '0;
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         r_clr_row    <= '0;
         r_clr_col    <= '0;
         r_clr_color  <= CLR_COLOR_RST;
         r_wr_dropped <= 1'b0;
      end else begin
         if (w_accept && !w_in_range) r_wr_dropped <= 1'b1;
         if (r_state == ST_IDLE && clr_req) begin
            r_clr_row   <= '0;
            r_clr_col   <= '0;
            r_clr_color <= clr_color;
         end else if (r_state == ST_CLEAR && rdn) begin
            if (r_clr_col == COL_MAX) begin
               r_clr_col <= '0;
               r_clr_row <= w_clr_last ? '0 : r_clr_row + ROW_W'(1);
            end else begin
               r_clr_col <= r_clr_col + COL_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: full-size instance plus a 4x8-pixel instance for a complete clear.
// Latency: checks RAM writes at the documented edges.
// Backpressure: exercises wr_ready and rdn stalls.
module tb_vram_arbiter;
   logic          vga_clk;
   logic          clrn;
   logic [8:0]    row_addr;
   logic [9:0]    col_addr;
   logic          rdn;
   logic          wr_valid;
   logic [8:0]    wr_row;
   logic [9:0]    wr_col;
   logic [11:0]   wr_data;
   logic          clr_req;
   logic [11:0]   clr_color;
   logic [11:0]   ram_rdata;

   logic [11:0]   d_in,      s_d_in;
   logic          wr_ready,  s_wr_ready;
   logic          clr_busy,  s_clr_busy;
   logic [18:0]   ram_addr,  s_ram_addr;
   logic          ram_we,    s_ram_we;
   logic [11:0]   ram_wdata, s_ram_wdata;
   logic [3:0]    fifo_level, s_fifo_level;
   logic          wr_dropped, s_wr_dropped;

   int            n_vec;
   int            n_miss;
   logic [30:0]   wq[$];
   logic [30:0]   s_wq[$];

   vram_arbiter #(.FIFO_DEPTH(8), .CLR_COLOR_RST(12'h000)) u_dut (
      .vga_clk(vga_clk), .clrn(clrn), .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn),
      .d_in(d_in), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
      .wr_data(wr_data), .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .fifo_level(fifo_level), .wr_dropped(wr_dropped)
   );

   vram_arbiter #(.FIFO_DEPTH(8), .CLR_COLOR_RST(12'h000), .V_PIX(4), .H_PIX(8)) u_small (
      .vga_clk(vga_clk), .clrn(clrn), .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn),
      .d_in(s_d_in), .wr_valid(wr_valid), .wr_ready(s_wr_ready), .wr_row(wr_row), .wr_col(wr_col),
      .wr_data(wr_data), .clr_req(clr_req), .clr_color(clr_color), .clr_busy(s_clr_busy),
      .ram_addr(s_ram_addr), .ram_we(s_ram_we), .ram_wdata(s_ram_wdata), .ram_rdata(ram_rdata),
      .fifo_level(s_fifo_level), .wr_dropped(s_wr_dropped)
   );

   initial vga_clk = 1'b0;
   always #20 vga_clk = ~vga_clk;

   // Record every write the RAM will commit at the following rising edge.
   always @(negedge vga_clk) begin
      if (ram_we)   wq.push_back({ram_addr, ram_wdata});
      if (s_ram_we) s_wq.push_back({s_ram_addr, s_ram_wdata});
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [30:0] ent(input logic [8:0] r, input logic [9:0] c, input logic [11:0] d);
      return {r, c, d};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge vga_clk);
         #1;
      end
   endtask

   task automatic push(input logic [8:0] r, input logic [9:0] c, input logic [11:0] d);
      wr_row   = r;
      wr_col   = c;
      wr_data  = d;
      wr_valid = 1'b1;
      step(1);
      wr_valid = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_miss = 0;
      clrn = 1'b1; rdn = 1'b1; row_addr = '0; col_addr = '0;
      wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
      clr_req = 1'b0; clr_color = '0; ram_rdata = '0;

      // Reset state
      #2 clrn = 1'b0; row_addr = 9'd5; col_addr = 10'd7;
      #5;
      check_vec("rst_level",   fifo_level, 0);
      check_vec("rst_ready",   wr_ready,   1);
      check_vec("rst_we",      ram_we,     0);
      check_vec("rst_wdata",   ram_wdata,  0);
      check_vec("rst_addr",    ram_addr,   0);
      check_vec("rst_busy",    clr_busy,   0);
      check_vec("rst_dropped", wr_dropped, 0);
      ram_rdata = 12'hA5C;
      #1 check_vec("d_in_pass", d_in, 12'hA5C);
      step(2);
      clrn = 1'b1;

      // Scan priority: three buffered writes held off by rdn=0
      rdn = 1'b0;
      push(9'd10, 10'd20, 12'h111);
      push(9'd11, 10'd21, 12'h222);
      push(9'd12, 10'd22, 12'h333);
      #1;
      check_vec("scan_addr",  ram_addr, {9'd5, 10'd7});
      check_vec("scan_we",    ram_we,   0);
      check_vec("scan_level", fifo_level, 3);
      step(2);
      check_vec("scan_level_hold", fifo_level, 3);
      wq.delete();
      rdn = 1'b1;
      step(3);
      #1;
      check_vec("drain_level", fifo_level, 0);
      check_vec("drain_idle_we", ram_we, 0);
      check_vec("drain_count", wq.size(), 3);
      check_vec("drain_w0", (wq.size() > 0) ? wq[0] : 31'h0, ent(9'd10, 10'd20, 12'h111));
      check_vec("drain_w1", (wq.size() > 1) ? wq[1] : 31'h0, ent(9'd11, 10'd21, 12'h222));
      check_vec("drain_w2", (wq.size() > 2) ? wq[2] : 31'h0, ent(9'd12, 10'd22, 12'h333));

      // Handshake: fill all 8 slots, 9th is refused
      rdn = 1'b0;
      for (int i = 0; i < 8; i++) push(9'(i), 10'(i + 1), 12'(12'h100 + i));
      #1;
      check_vec("hs_ready_full", wr_ready, 0);
      check_vec("hs_level_full", fifo_level, 8);
      wr_row = 9'd9; wr_col = 10'd9; wr_data = 12'hABC; wr_valid = 1'b1;
      step(2);
      wr_valid = 1'b0;
      check_vec("hs_ninth_refused", fifo_level, 8);
      wq.delete();
      rdn = 1'b1;
      step(10);
      check_vec("hs_count", wq.size(), 8);
      for (int i = 0; i < 8; i++)
         check_vec("hs_order", (i < wq.size()) ? wq[i] : 31'h0, ent(9'(i), 10'(i + 1), 12'(12'h100 + i)));
      check_vec("hs_level_empty", fifo_level, 0);

      // Out-of-range write is swallowed
      wq.delete();
      push(9'd480, 10'd0, 12'hFFF);
      #1;
      check_vec("oor_dropped", wr_dropped, 1);
      check_vec("oor_level",   fifo_level, 0);
      step(3);
      check_vec("oor_no_write", wq.size(), 0);

      // Last legal pixel, with the N+2 write latency
      push(9'd479, 10'd639, 12'h0F0);
      #1;
      check_vec("lat_n1_we",    ram_we,     0);
      check_vec("lat_n1_level", fifo_level, 1);
      step(1);
      check_vec("lat_we",    ram_we,    1);
      check_vec("lat_addr",  ram_addr,  {9'd479, 10'd639});
      check_vec("lat_wdata", ram_wdata, 12'h0F0);
      step(1);
      check_vec("lat_done_we",    ram_we,     0);
      check_vec("lat_done_level", fifo_level, 0);

      // Clear on both instances; the 4x8 one runs to completion
      wq.delete();
      s_wq.delete();
      clr_color = 12'h00F; clr_req = 1'b1;
      step(1);
      clr_req = 1'b0; clr_color = 12'h0A0;
      #1;
      check_vec("clr_busy",    clr_busy,   1);
      check_vec("s_clr_busy",  s_clr_busy, 1);
      check_vec("clr_first_we",    ram_we,    1);
      check_vec("clr_first_addr",  ram_addr,  0);
      check_vec("clr_first_wdata", ram_wdata, 12'h00F);
      push(9'd2, 10'd3, 12'h777);
      rdn = 1'b0; clr_req = 1'b1; clr_color = 12'hF00;
      step(1);
      clr_req = 1'b0;
      step(2);
      rdn = 1'b1;
      check_vec("clr_fifo_held", fifo_level, 1);
      for (int k = 0; k < 200 && s_clr_busy; k++) step(1);
      check_vec("s_clr_done", s_clr_busy, 0);
      step(3);
      check_vec("s_clr_count", s_wq.size(), 33);
      check_vec("s_clr_first", (s_wq.size() > 0)  ? s_wq[0]  : 31'h0, ent(9'd0, 10'd0, 12'h00F));
      check_vec("s_clr_wrap",  (s_wq.size() > 8)  ? s_wq[8]  : 31'h0, ent(9'd1, 10'd0, 12'h00F));
      check_vec("s_clr_last",  (s_wq.size() > 31) ? s_wq[31] : 31'h0, ent(9'd3, 10'd7, 12'h00F));
      check_vec("s_clr_draw",  (s_wq.size() > 32) ? s_wq[32] : 31'h0, ent(9'd2, 10'd3, 12'h777));
      check_vec("s_level_end", s_fifo_level, 0);

      // Full-size clear: reach pixel 1000, then reset mid-clear
      for (int k = 0; k < 2000 && wq.size() < 1000; k++) step(1);
      check_vec("clr_reach_1000", (wq.size() >= 1000) ? 1 : 0, 1);
      check_vec("clr_px999", (wq.size() > 999) ? wq[999] : 31'h0, ent(9'd1, 10'd359, 12'h00F));
      check_vec("clr_busy_mid",  clr_busy,   1);
      check_vec("clr_level_mid", fifo_level, 1);
      clrn = 1'b0;
      #1;
      check_vec("rstmid_we",   ram_we,   0);
      check_vec("rstmid_addr", ram_addr, 0);
      step(2);
      clrn = 1'b1;
      #1;
      check_vec("rstmid_busy",    clr_busy,   0);
      check_vec("rstmid_level",   fifo_level, 0);
      check_vec("rstmid_ready",   wr_ready,   1);
      check_vec("rstmid_dropped", wr_dropped, 0);
      step(2);
      check_vec("rstmid_quiet", ram_we, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
